// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Fetch/data arbiter for a single-ported memory with starvation cap
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] C_MAX_WAIT = 3'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t     r_state;
    logic [2:0] r_starve_cnt;
    logic       w_idle;
    logic       w_fetch_wins;

    // Grants are combinational so a request is accepted in the cycle it is seen.
    assign w_idle       = (r_state == IDLE) && !rst;
    assign w_fetch_wins = if_req && (!d_req || (r_starve_cnt == C_MAX_WAIT));
    assign if_gnt       = w_idle && w_fetch_wins;
    assign d_gnt        = w_idle && d_req && !w_fetch_wins;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= 3'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_rvalid    <= 1'b0;
            d_rvalid     <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (if_gnt) begin
                        r_state      <= BUSY_IF;
                        r_starve_cnt <= 3'd0;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= if_addr;
                        mem_wdata    <= '0;
                    end else if (d_gnt) begin
                        r_state   <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        // Fetch lost a contested round; count towards forcing it through.
                        if (if_req && (r_starve_cnt != C_MAX_WAIT)) begin
                            r_starve_cnt <= r_starve_cnt + 3'd1;
                        end
                    end
                end
                BUSY_IF: begin
                    if (mem_ack) begin
                        if_rdata  <= mem_rdata;
                        if_rvalid <= 1'b1;
                        mem_req   <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        d_rdata  <= mem_rdata;
                        d_rvalid <= 1'b1;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Directed self-checking bench for mem_arbiter
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int          errors = 0;
    int          checks = 0;
    int          lat    = 1;
    bit          resp_en = 1'b1;
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rdata(if_rdata), .if_rvalid(if_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Memory model: acks in the lat-th cycle that mem_req is high.
    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i * 3);
        mem[8'h10] = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                if (mem_req) begin
                    cnt++;
                    if (cnt >= lat) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem[mem_addr[9:2]];
                        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
                        cnt = 0;
                    end else begin
                        mem_ack = 1'b0;
                    end
                end else begin
                    mem_ack = 1'b0;
                    cnt = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h4; d_req = 1'b1; d_we = 1'b1;
        d_addr = 32'h8; d_wdata = 32'h55;
        tick(); tick();
        #1;
        checks++;
        if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin
            errors++; $display("FAIL reset_gnt: if_gnt=%b d_gnt=%b required 0 0", if_gnt, d_gnt);
        end
        checks++;
        if ({mem_req, mem_we, if_rvalid, d_rvalid} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: req/we/ifrv/drv=%b required 0000", {mem_req, mem_we, if_rvalid, d_rvalid});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_data: addr=%h wdata=%h ifrd=%h drd=%h required all 0", mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        checks++;
        if (dut.r_starve_cnt !== 3'd0) begin
            errors++; $display("FAIL reset_starve: got %0d required 0", dut.r_starve_cnt);
        end
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_load();
        lat = 2;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        #1;
        checks++;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            errors++; $display("FAIL load_gnt: d_gnt=%b if_gnt=%b required 1 0", d_gnt, if_gnt);
        end
        tick(); d_req = 1'b0; #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
            errors++; $display("FAIL load_c1: req=%b addr=%h we=%b required 1 00000040 0", mem_req, mem_addr, mem_we);
        end
        tick(); #1;
        checks++;
        if (mem_req !== 1'b1 || d_rvalid !== 1'b0) begin
            errors++; $display("FAIL load_c2: req=%b d_rvalid=%b required 1 0", mem_req, d_rvalid);
        end
        tick(); #1;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF || mem_req !== 1'b0) begin
            errors++; $display("FAIL load_c3: rvalid=%b rdata=%h req=%b required 1 deadbeef 0", d_rvalid, d_rdata, mem_req);
        end
        tick(); #1;
        checks++;
        if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
            errors++; $display("FAIL load_c4: d_rvalid=%b if_rvalid=%b required 0 0", d_rvalid, if_rvalid);
        end
        tick();
    endtask

    task automatic test_store();
        int held, bad, drv, ifrv;
        held = 0; bad = 0; drv = 0; ifrv = 0;
        lat = 3;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234_5678;
        #1;
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++; $display("FAIL store_gnt: d_gnt=%b required 1", d_gnt);
        end
        tick(); d_req = 1'b0; d_we = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (mem_req) begin
                held++;
                if (mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'h1234_5678) bad++;
            end
            if (d_rvalid) drv++;
            if (if_rvalid) ifrv++;
            tick();
        end
        checks++;
        if (held !== 3 || bad !== 0) begin
            errors++; $display("FAIL store_hold: cycles=%0d bad=%0d required 3 0", held, bad);
        end
        checks++;
        if (drv !== 1 || ifrv !== 0) begin
            errors++; $display("FAIL store_rvalid: d_pulses=%0d if_pulses=%0d required 1 0", drv, ifrv);
        end
        checks++;
        if (mem[8'h20] !== 32'h1234_5678) begin
            errors++; $display("FAIL store_mem: got %h required 12345678", mem[8'h20]);
        end
    endtask

    task automatic test_contention();
        bit order [$];
        bit exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int both;
        both = 0;
        lat = 1;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (if_gnt && d_gnt) both++;
            if (if_gnt) order.push_back(1'b1);
            else if (d_gnt) order.push_back(1'b0);
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        checks++;
        if (both !== 0) begin
            errors++; $display("FAIL contention_both: cycles=%0d required 0", both);
        end
        checks++;
        if (order.size() < 10) begin
            errors++; $display("FAIL contention_count: grants=%0d required >=10", order.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (order[i] !== exp_order[i]) begin
                    errors++; $display("FAIL contention_order[%0d]: got %s required %s", i,
                                       order[i] ? "IF" : "D", exp_order[i] ? "IF" : "D");
                end
            end
        end
        tick(); tick(); tick();
    endtask

    task automatic test_back_to_back();
        int idx, rv, badwe, badgnt;
        idx = 0; rv = 0; badwe = 0; badgnt = 0;
        lat = 1;
        if_req = 1'b1; if_addr = 32'h0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (if_gnt) begin
                if (c != 2 * idx) badgnt++;
                idx++;
            end
            if (if_rvalid) begin
                checks++;
                if (if_rdata !== 32'h1000_0000 + 32'(rv * 3) || c != 2 * rv + 2) begin
                    errors++; $display("FAIL fetch_data[%0d]: got %h at cycle %0d required %h at cycle %0d",
                                       rv, if_rdata, c, 32'h1000_0000 + 32'(rv * 3), 2 * rv + 2);
                end
                rv++;
            end
            if (mem_we !== 1'b0 || d_rvalid !== 1'b0) badwe++;
            tick();
            if_addr = 32'(idx * 4);
            if_req  = (idx < 3);
        end
        checks++;
        if (idx !== 3 || badgnt !== 0) begin
            errors++; $display("FAIL fetch_gnt: grants=%0d off_cycle=%0d required 3 0", idx, badgnt);
        end
        checks++;
        if (rv !== 3 || badwe !== 0) begin
            errors++; $display("FAIL fetch_rv: pulses=%0d bad_we=%0d required 3 0", rv, badwe);
        end
    endtask

    task automatic test_reset_mid();
        int drv;
        drv = 0;
        lat = 100;
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        #1;
        checks++;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            errors++; $display("FAIL rstmid_gnt: d_gnt=%b if_gnt=%b required 1 0", d_gnt, if_gnt);
        end
        tick(); if_req = 1'b0; d_req = 1'b0; #1;
        checks++;
        if (mem_req !== 1'b1 || dut.r_starve_cnt !== 3'd1) begin
            errors++; $display("FAIL rstmid_busy: req=%b starve=%0d required 1 1", mem_req, dut.r_starve_cnt);
        end
        rst = 1'b1;
        tick(); rst = 1'b0;
        resp_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || dut.r_starve_cnt !== 3'd0) begin
            errors++; $display("FAIL rstmid_clear: req=%b starve=%0d required 0 0", mem_req, dut.r_starve_cnt);
        end
        tick(); mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (d_rvalid || if_rvalid) drv++;
            tick();
        end
        checks++;
        if (drv !== 0) begin
            errors++; $display("FAIL rstmid_rvalid: pulses=%0d required 0", drv);
        end
        resp_en = 1'b1; lat = 1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
        #1;
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++; $display("FAIL rstmid_idle: d_gnt=%b required 1", d_gnt);
        end
        tick(); d_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_spurious();
        logic [31:0] ifrd0, drd0, addr0;
        int bad;
        bad = 0;
        ifrd0 = if_rdata; drd0 = d_rdata; addr0 = mem_addr;
        resp_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (if_gnt || d_gnt || if_rvalid || d_rvalid || mem_req) bad++;
            tick();
        end
        mem_ack = 1'b0; resp_en = 1'b1;
        #1;
        checks++;
        if (bad !== 0 || if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            errors++; $display("FAIL spurious_ctrl: bad_cycles=%0d required 0", bad);
        end
        checks++;
        if (if_rdata !== ifrd0 || d_rdata !== drd0 || mem_addr !== addr0) begin
            errors++; $display("FAIL spurious_data: ifrd=%h drd=%h addr=%h required %h %h %h",
                               if_rdata, d_rdata, mem_addr, ifrd0, drd0, addr0);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_store();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_spurious();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data bus width.
REQ-002 Parameter ADDR_W, default 32, address bus width.
REQ-003 Parameter MAX_WAIT, default 4, range 1..7, consecutive fetch losses before fetch is forced to win.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 if_req  input  1  fetch request; held with if_addr until if_gnt.
REQ-007 if_addr  input  ADDR_W  fetch address.
REQ-008 if_gnt  output  1  one-cycle fetch grant pulse.
REQ-009 if_rdata  output  DATA_W  fetched instruction, valid while if_rvalid.
REQ-010 if_rvalid  output  1  one-cycle fetch completion pulse.
REQ-011 d_req  input  1  load/store request; held with d_we/d_addr/d_wdata until d_gnt.
REQ-012 d_we  input  1  1 = store, 0 = load.
REQ-013 d_addr  input  ADDR_W  data address.
REQ-014 d_wdata  input  DATA_W  store data.
REQ-015 d_gnt  output  1  one-cycle data grant pulse.
REQ-016 d_rdata  output  DATA_W  load data, valid while d_rvalid.
REQ-017 d_rvalid  output  1  one-cycle data completion pulse (loads and stores).
REQ-018 mem_req  output  1  request to the single-ported memory.
REQ-019 mem_we  output  1  write enable to memory.
REQ-020 mem_addr  output  ADDR_W  memory address.
REQ-021 mem_wdata  output  DATA_W  memory write data.
REQ-022 mem_ack  input  1  memory completion, one cycle, any latency >= 1 cycle after mem_req rises.
REQ-023 mem_rdata  input  DATA_W  memory read data, valid with mem_ack.

Function
REQ-024 FSM states IDLE, BUSY_IF, BUSY_D; exactly one transaction outstanding at any time.
REQ-025 IDLE, no request: stay IDLE, no grants.
REQ-026 IDLE, one requester: grant it combinationally that cycle; latch addr/we/wdata; next state BUSY_IF or BUSY_D.
REQ-027 IDLE, both requesting: data wins unless starve_cnt == MAX_WAIT, then fetch wins.
REQ-028 starve_cnt (3 bit): +1 when both request and data wins; cleared whenever fetch is granted; saturates at MAX_WAIT.
REQ-029 BUSY_*: mem_req = 1 with latched mem_addr/mem_we/mem_wdata held stable until mem_ack; mem_we = 0 in BUSY_IF.
REQ-030 BUSY_* with mem_ack: register mem_rdata into owner's rdata; owner's rvalid = 1 next cycle only; next state IDLE.
REQ-031 Store completion: d_rvalid pulses; d_rdata value unspecified.
REQ-032 Back-to-back: the IDLE cycle carrying rvalid may grant a new request; minimum throughput one transaction per 2 cycles + memory latency.
REQ-033 Minimum latency: gnt cycle N, mem_req cycle N+1, mem_ack earliest N+1, rvalid N+2.
REQ-034 mem_ack while IDLE is ignored; no rvalid, no state change.
REQ-035 if_gnt and d_gnt never high in the same cycle; gnt only in IDLE.
REQ-036 Requests deasserted before grant are dropped without effect.

Reset
REQ-037 rst = 1 at a clock edge: state IDLE, starve_cnt 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, if_rvalid 0, d_rvalid 0, if_rdata 0, d_rdata 0; if_gnt/d_gnt 0 while rst = 1.
REQ-038 Reset during BUSY_*: transaction abandoned, no rvalid issued; late mem_ack is ignored per REQ-034.

Verification
REQ-039 Single load: d_req, d_we=0, d_addr=0x40; mem_ack 2 cycles after mem_req with mem_rdata=0xDEADBEEF -> d_gnt cycle 0, mem_req cycles 1-2, d_rvalid cycle 3 with d_rdata=0xDEADBEEF.
REQ-040 Store: d_we=1, d_addr=0x80, d_wdata=0x12345678 -> mem_we=1, mem_addr=0x80, mem_wdata=0x12345678 until ack; d_rvalid one pulse; if_rvalid stays 0.
REQ-041 Contention: if_req and d_req both held continuously, MAX_WAIT=4, ack latency 1 -> grant order D,D,D,D,IF,D,D,D,D,IF; never both gnt in one cycle.
REQ-042 Fetch only: if_addr=0x0,0x4,0x8 back-to-back, ack latency 1 -> if_gnt every 2 cycles, if_rdata matches per address, mem_we always 0.
REQ-043 Reset mid-operation: rst in BUSY_D before ack, then mem_ack -> mem_req 0 next cycle, no d_rvalid, FSM IDLE, starve_cnt 0.
REQ-044 Spurious ack: mem_ack=1 while IDLE with no requests -> no rvalid, no grant, outputs unchanged.
